// File: rtl/ghostbus_pkg.sv
// Shared ghostbus definitions: bridge FSM states, latency counter width and
// default bus geometry.
`timescale 1ns/1ps
package ghostbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } gb_state_e;

  localparam int LAT_W  = 4;
  localparam int DEF_AW = 24;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/ghostbus_host_bridge.sv
// Host command stream to single ghostbus transaction bridge: one strobe per
// command, read data sampled RD_LAT cycles after gb_re, one in-order response.
`timescale 1ns/1ps
module ghostbus_host_bridge
  import ghostbus_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_write,
  output logic [DW-1:0] resp_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_rdata
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("ghostbus_host_bridge: RD_LAT=%0d outside legal range 1..15", RD_LAT);
  end

  gb_state_e            state_q, state_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_write_q, resp_write_d;
  logic [DW-1:0]        resp_rdata_q, resp_rdata_d;
  logic [AW-1:0]        gb_addr_q, gb_addr_d;
  logic [DW-1:0]        gb_wdata_q, gb_wdata_d;
  logic                 gb_we_q, gb_we_d;
  logic                 gb_re_q, gb_re_d;
  logic                 accept;

  // Every output is a flop, so resp_ready and cmd_valid never reach an output combinationally.
  assign accept = cmd_valid && cmd_ready_q;

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    cmd_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_write_d = resp_write_q;
    resp_rdata_d = resp_rdata_q;
    gb_addr_d    = gb_addr_q;
    gb_wdata_d   = gb_wdata_q;
    gb_we_d      = 1'b0;
    gb_re_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          gb_addr_d    = cmd_addr;
          gb_wdata_d   = cmd_wdata;
          resp_write_d = cmd_write;
          resp_rdata_d = '0;
          gb_we_d      = cmd_write;
          gb_re_d      = !cmd_write;
          state_d      = ST_STROBE;
        end else begin
          cmd_ready_d  = 1'b1;
        end
      end
      ST_STROBE: begin
        if (resp_write_q) begin
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          lat_cnt_d    = LAT_W'(RD_LAT - 1);
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter reaching zero marks the single cycle where gb_rdata is valid.
        if (lat_cnt_q == '0) begin
          resp_rdata_d = gb_rdata;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          lat_cnt_d    = lat_cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          cmd_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= '0;
      cmd_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
      gb_addr_q    <= '0;
      gb_wdata_q   <= '0;
      gb_we_q      <= 1'b0;
      gb_re_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_rdata_q <= resp_rdata_d;
      gb_addr_q    <= gb_addr_d;
      gb_wdata_q   <= gb_wdata_d;
      gb_we_q      <= gb_we_d;
      gb_re_q      <= gb_re_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_rdata = resp_rdata_q;
  assign gb_addr    = gb_addr_q;
  assign gb_wdata   = gb_wdata_q;
  assign gb_we      = gb_we_q;
  assign gb_re      = gb_re_q;

endmodule

// File: tb/tb_ghostbus_host_bridge.sv
// Bench for ghostbus_host_bridge: bus-side memory model, in-order response
// scoreboard, table-driven back-to-back vectors and hand-written corner sequences.
`timescale 1ns/1ps
module tb_ghostbus_host_bridge;

  localparam int AW  = 24;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, gb_addr;
  logic [DW-1:0] cmd_wdata, resp_rdata, gb_wdata, gb_rdata;
  logic          resp_valid, resp_write, gb_we, gb_re;
  logic          resp_ready = 1'b0;

  logic          cmd_valid_1, cmd_ready_1, cmd_write_1;
  logic [AW-1:0] cmd_addr_1, gb_addr_1;
  logic [DW-1:0] cmd_wdata_1, resp_rdata_1, gb_wdata_1, gb_rdata_1;
  logic          resp_valid_1, resp_ready_1, resp_write_1, gb_we_1, gb_re_1;

  ghostbus_host_bridge #(.AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
    .gb_rdata(gb_rdata)
  );

  ghostbus_host_bridge #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1), .cmd_write(cmd_write_1),
    .cmd_addr(cmd_addr_1), .cmd_wdata(cmd_wdata_1),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready_1), .resp_write(resp_write_1),
    .resp_rdata(resp_rdata_1),
    .gb_addr(gb_addr_1), .gb_wdata(gb_wdata_1), .gb_we(gb_we_1), .gb_re(gb_re_1),
    .gb_rdata(gb_rdata_1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Target contents before any write: a fixed function of the address.
  function automatic logic [31:0] dflt(input logic [23:0] a);
    return 32'hA500_0000 ^ {8'h00, a};
  endfunction

  typedef struct packed { logic w; logic [23:0] a; logic [31:0] d; } strb_t;
  typedef struct packed { logic w; logic [31:0] rd; } resp_t;

  logic [31:0] model_mem [logic [23:0]];
  logic [31:0] bus_mem   [logic [23:0]];
  strb_t exp_strb[$];
  resp_t exp_resp[$];
  resp_t got_resp[$];

  int acc_cyc, strb_cyc, rfirst_cyc;
  logic busy, chk_ready_next, prev_rv, prev_w;
  logic [31:0] prev_rd;
  logic pend_v;
  int pend_due;
  logic [31:0] pend_d;
  int rr_mode = 0;
  strb_t ms;
  resp_t mr;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = 1'($urandom % 2);
      default: resp_ready = 1'b0;
    endcase
  end

  // Ghostbus target, reference model and response scoreboard, all sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_strb.delete();
      exp_resp.delete();
      busy = 1'b0;
      chk_ready_next = 1'b0;
      prev_rv = 1'b0;
      pend_v = 1'b0;
      gb_rdata = '0;
    end else begin
      check("we_re_exclusive", {1'b0, gb_we & gb_re}, 0);
      if (gb_we || gb_re) begin
        strb_cyc = cyc;
        check("strobe_expected", {1'b0, exp_strb.size() != 0}, 1);
        if (exp_strb.size() != 0) begin
          ms = exp_strb.pop_front();
          check("strobe_kind", {1'b0, gb_we}, {1'b0, ms.w});
          check("strobe_addr", gb_addr, ms.a);
          if (ms.w) check("strobe_wdata", gb_wdata, ms.d);
        end
        if (gb_we) bus_mem[gb_addr] = gb_wdata;
        if (gb_re) begin
          pend_v = 1'b1;
          pend_due = cyc + LAT;
          pend_d = bus_mem.exists(gb_addr) ? bus_mem[gb_addr] : dflt(gb_addr);
        end
      end
      if (pend_v && pend_due == cyc) begin
        gb_rdata = pend_d;
        pend_v = 1'b0;
      end else begin
        gb_rdata = $urandom;
      end

      if (chk_ready_next) begin
        check("ready_after_resp", {1'b0, cmd_ready}, 1);
        chk_ready_next = 1'b0;
      end else if (busy) begin
        check("ready_low_busy", {1'b0, cmd_ready}, 0);
      end

      if (resp_valid && !prev_rv) rfirst_cyc = cyc;
      if (resp_valid && prev_rv) begin
        check("resp_write_stable", {1'b0, resp_write}, {1'b0, prev_w});
        check("resp_rdata_stable", resp_rdata, prev_rd);
      end
      if (resp_valid && resp_ready) begin
        check("resp_expected", {1'b0, exp_resp.size() != 0}, 1);
        if (exp_resp.size() != 0) begin
          mr = exp_resp.pop_front();
          check("resp_write", {1'b0, resp_write}, {1'b0, mr.w});
          check("resp_rdata", resp_rdata, mr.rd);
        end
        got_resp.push_back('{w: resp_write, rd: resp_rdata});
        busy = 1'b0;
        chk_ready_next = 1'b1;
        prev_rv = 1'b0;
      end else begin
        prev_rv = resp_valid;
        prev_w  = resp_write;
        prev_rd = resp_rdata;
      end

      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc;
        busy = 1'b1;
        exp_strb.push_back('{w: cmd_write, a: cmd_addr, d: cmd_wdata});
        if (cmd_write) begin
          model_mem[cmd_addr] = cmd_wdata;
          exp_resp.push_back('{w: 1'b1, rd: 32'h0});
        end else begin
          exp_resp.push_back('{w: 1'b0,
            rd: model_mem.exists(cmd_addr) ? model_mem[cmd_addr] : dflt(cmd_addr)});
        end
      end
    end
  end

  task automatic send(input logic w, input logic [23:0] a, input logic [31:0] d);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("send_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_resp.size() == 0) return;
    end
    check("drain_timeout", 0, 1);
  endtask

  typedef struct { logic w; logic [23:0] a; logic [31:0] d; logic [31:0] exp_rd; } vec_t;
  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [23:0] addrs [5];
    logic [23:0] ra;
    logic rw;

    vecs[0] = '{1'b1, 24'hFFFFFF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 24'hFFFFFF, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 24'h000100, 32'h01234567, 32'h0};
    vecs[3] = '{1'b1, 24'hFFFFFF, 32'h0BADF00D, 32'h0};
    vecs[4] = '{1'b0, 24'h000100, 32'h0,        32'h01234567};
    vecs[5] = '{1'b0, 24'hFFFFFF, 32'h0,        32'h0BADF00D};
    vecs[6] = '{1'b1, 24'h000000, 32'hFFFFFFFF, 32'h0};
    vecs[7] = '{1'b0, 24'h000000, 32'h0,        32'hFFFFFFFF};

    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    cmd_valid_1 = 0; cmd_write_1 = 0; cmd_addr_1 = '0; cmd_wdata_1 = '0;
    resp_ready_1 = 1'b1; gb_rdata_1 = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready",  {1'b0, cmd_ready}, 0);
    check("rst_resp_valid", {1'b0, resp_valid}, 0);
    check("rst_gb_we",      {1'b0, gb_we}, 0);
    check("rst_gb_re",      {1'b0, gb_re}, 0);
    check("rst_gb_addr",    gb_addr, 0);
    check("rst_gb_wdata",   gb_wdata, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_write", {1'b0, resp_write}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {1'b0, cmd_ready}, 1);

    // 1: single write
    rr_mode = 0;
    send(1'b1, 24'h000010, 32'hDEADBEEF);
    cmd_valid = 0;
    drain();
    check("wr_strobe_latency", strb_cyc - acc_cyc, 1);
    check("wr_resp_latency", rfirst_cyc - acc_cyc, 2);
    check("wr_resp_write", {1'b0, got_resp[got_resp.size()-1].w}, 1);
    check("wr_resp_rdata", got_resp[got_resp.size()-1].rd, 0);

    // 2: read with RD_LAT=3
    send(1'b1, 24'h000020, 32'h12345678);
    cmd_valid = 0;
    drain();
    send(1'b0, 24'h000020, 32'h0);
    cmd_valid = 0;
    drain();
    check("rd_strobe_latency", strb_cyc - acc_cyc, 1);
    check("rd_resp_latency", rfirst_cyc - acc_cyc, 2 + LAT);
    check("rd_resp_rdata", got_resp[got_resp.size()-1].rd, 32'h12345678);

    // 3: response stalled by resp_ready=0
    rr_mode = 2;
    send(1'b0, 24'h000010, 32'h0);
    cmd_valid = 0;
    for (int i = 0; i < 50 && !resp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("stall_resp_seen", {1'b0, resp_valid}, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("stall_resp_valid", {1'b0, resp_valid}, 1);
      check("stall_rdata", resp_rdata, 32'hDEADBEEF);
      check("stall_cmd_ready", {1'b0, cmd_ready}, 0);
    end
    rr_mode = 0;
    drain();

    // 4: back-to-back table vectors with cmd_valid held high
    rr_mode = 1;
    base = got_resp.size();
    for (int i = 0; i < 8; i++) send(vecs[i].w, vecs[i].a, vecs[i].d);
    cmd_valid = 0;
    drain();
    check("table_resp_count", got_resp.size() - base, 8);
    for (int i = 0; i < 8 && base + i < got_resp.size(); i++) begin
      check($sformatf("table_%0d_write", i), {1'b0, got_resp[base+i].w}, {1'b0, vecs[i].w});
      check($sformatf("table_%0d_rdata", i), got_resp[base+i].rd, vecs[i].exp_rd);
    end

    // 5: reset during the WAIT phase of a read
    rr_mode = 0;
    send(1'b0, 24'h000020, 32'h0);
    cmd_valid = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_gb_re", {1'b0, gb_re}, 0);
    check("abort_gb_we", {1'b0, gb_we}, 0);
    check("abort_resp_valid", {1'b0, resp_valid}, 0);
    check("abort_cmd_ready", {1'b0, cmd_ready}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("no_stale_resp", {1'b0, resp_valid}, 0);
    end
    send(1'b0, 24'h000100, 32'h0);
    cmd_valid = 0;
    drain();
    check("post_abort_rdata", got_resp[got_resp.size()-1].rd, 32'h01234567);

    // Randomized traffic against the reference model
    rr_mode = 1;
    addrs[0] = 24'h000010; addrs[1] = 24'h000020; addrs[2] = 24'h000100;
    addrs[3] = 24'hFFFFFF; addrs[4] = 24'h000000;
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom % 2);
      ra = ($urandom % 6 == 5) ? 24'($urandom) : addrs[$urandom % 5];
      send(rw, ra, $urandom);
      if ($urandom % 2 == 1) begin
        cmd_valid = 0;
        cmd_write = 1'($urandom);
        cmd_addr  = 24'($urandom);
        cmd_wdata = $urandom;
        repeat ($urandom % 3) @(posedge clk);
        #1;
      end
    end
    cmd_valid = 0;
    drain();
    rr_mode = 0;

    // 6: RD_LAT=1 instance, data valid only during cycle N+2
    cmd_write_1 = 1'b0;
    cmd_addr_1  = 24'hABCDEF;
    cmd_valid_1 = 1'b1;
    begin
      bit acc = 0;
      for (int i = 0; i < 20 && !acc; i++) begin
        @(negedge clk);
        gb_rdata_1 = 32'h5555_5555;
        if (cmd_ready_1) acc = 1;
      end
      check("lat1_accepted", {1'b0, acc}, 1);
    end
    @(negedge clk);
    cmd_valid_1 = 1'b0;
    check("lat1_gb_re", {1'b0, gb_re_1}, 1);
    check("lat1_gb_addr", gb_addr_1, 24'hABCDEF);
    gb_rdata_1 = 32'h1111_1111;
    @(negedge clk);
    check("lat1_resp_early", {1'b0, resp_valid_1}, 0);
    gb_rdata_1 = 32'hCAFEF00D;
    @(negedge clk);
    gb_rdata_1 = 32'h2222_2222;
    check("lat1_resp_valid", {1'b0, resp_valid_1}, 1);
    check("lat1_resp_rdata", resp_rdata_1, 32'hCAFEF00D);
    check("lat1_resp_write", {1'b0, resp_write_1}, 0);
    @(negedge clk);
    check("lat1_resp_done", {1'b0, resp_valid_1}, 0);
    check("lat1_ready_again", {1'b0, cmd_ready_1}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
